// File: rtl/apb_bus_rr_master_if.sv
// apb_bus_rr_master_if: requester-side handshake plus APB bus signals of the round-robin APB master
interface apb_bus_rr_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [1:0]          REQ;
  logic [1:0]          REQ_WRITE;
  logic [2*ADDR_W-1:0] REQ_ADDR;
  logic [2*DATA_W-1:0] REQ_WDATA;
  logic [1:0]          DONE;
  logic [DATA_W-1:0]   RDATA;
  logic                ERR;
  logic                GNT_ID;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  modport master (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY,
    output DONE, RDATA, ERR, GNT_ID, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY,
    input  DONE, RDATA, ERR, GNT_ID, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_bus_rr_master.sv
// apb_bus_rr_master: shares one APB bus between two requesters with round-robin arbitration.
// Defining APB_RR_TIMEOUT_EN aborts an ACCESS phase with ERR=1 after TIMEOUT wait cycles.
module apb_bus_rr_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic SYSCLK,
  input logic RST_B,
  apb_bus_rr_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
  state_t            state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d, gnt_q, gnt_d, last_q, last_d;
  logic              win, finish;
`ifdef APB_RR_TIMEOUT_EN
  logic [7:0]        wait_q, wait_d;
`endif
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    done_d    = 2'b00;
    finish    = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    // on contention the requester not served last wins
    win = &bus.REQ ? ~last_q : bus.REQ[1];
    case (state_q)
      S_IDLE: if (|bus.REQ) begin
        state_d  = S_SETUP;
        psel_d   = 1'b1;
        gnt_d    = win;
        pwrite_d = bus.REQ_WRITE[win];
        paddr_d  = win ? bus.REQ_ADDR[2*ADDR_W-1:ADDR_W] : bus.REQ_ADDR[ADDR_W-1:0];
        pwdata_d = win ? bus.REQ_WDATA[2*DATA_W-1:DATA_W] : bus.REQ_WDATA[DATA_W-1:0];
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_RR_TIMEOUT_EN
        wait_d    = 8'd0;
`endif
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          finish  = 1'b1;
          rdata_d = pwrite_q ? '0 : bus.PRDATA;
          err_d   = 1'b0;
        end
`ifdef APB_RR_TIMEOUT_EN
        else if (wait_q == 8'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
        end else wait_d = wait_q + 8'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      state_d   = S_DONE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = '0;
      pwdata_d  = '0;
      done_d    = gnt_q ? 2'b10 : 2'b01;
      last_d    = gnt_q;
    end
  end
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
    end
  end
`ifdef APB_RR_TIMEOUT_EN
  always_ff @(posedge SYSCLK) begin
    if (!RST_B) wait_q <= 8'd0;
    else wait_q <= wait_d;
  end
`endif
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.RDATA   = rdata_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.GNT_ID  = gnt_q;
endmodule

// File: doc/apb_bus_rr_master.md
Name: apb_bus_rr_master

Overview:
- Two-requester APB master that shares one APB bus between two on-chip initiators. Requester 0 is the CPU-side register agent; requester 1 is a DMA/config sequencer.
- Arbitrates round-robin and latches the winner's command. Drives the standard APB SETUP/ACCESS sequence on PSEL/PENABLE/PWRITE/PADDR/PWDATA, then returns read data and completion to the winner.
- Sits between the initiators and the APB slave register blocks, in place of a single fixed bus driver.

Parameters:
- ADDR_W, 5, APB address width (PADDR).
- DATA_W, 32, APB data width (PWDATA/PRDATA, request write data, RDATA).
- TIMEOUT, 16, ACCESS-phase wait limit in cycles. Used only when APB_RR_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- SYSCLK  in  1  system clock; all logic is clocked on its rising edge.
- RST_B  in  1  reset, synchronous and active-low, sampled on the rising edge of SYSCLK.
- REQ  in  2  per-requester request; bit i belongs to requester i. Held high until DONE[i].
- REQ_WRITE  in  2  per-requester direction: 1 = write, 0 = read.
- REQ_ADDR  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- REQ_WDATA  in  2*DATA_W  requester i write data in bits [i*DATA_W +: DATA_W].
- DONE  out  2  one-cycle completion pulse to the granted requester.
- RDATA  out  DATA_W  read data; valid only while DONE is nonzero.
- ERR  out  1  transfer aborted; valid only while DONE is nonzero.
- GNT_ID  out  1  index of the requester currently owning the bus.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data from the slave.
- PREADY  in  1  APB slave ready.

Behaviour:
- All outputs are registered.
- Reset (RST_B=0 at a clock edge):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, DONE, RDATA, ERR and GNT_ID all go to 0.
  - The round-robin pointer is reset so that requester 0 has priority.
  - Reset asserted mid-transfer abandons the transfer: no DONE, and the bus is idle from the next edge.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If no REQ bit is set, stay in IDLE.
  - If exactly one REQ bit is set, grant it.
  - If both bits are set, grant the requester not served last (round-robin pointer).
  - On grant, latch REQ_WRITE/REQ_ADDR/REQ_WDATA of the winner into PWRITE/PADDR/PWDATA, set PSEL=1 and GNT_ID=winner, then go to SETUP.
- SETUP: lasts exactly one cycle with PSEL=1, PENABLE=0. Set PENABLE=1 and go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, data and direction held stable.
  - If PREADY=1 on an edge: capture PRDATA into RDATA (reads only; writes give RDATA=0) and set ERR=0.
  - On that same edge, drop PSEL, PENABLE, PWRITE, PADDR and PWDATA to 0, pulse DONE[GNT_ID]=1, update the round-robin pointer, and go to DONE.
  - If PREADY=0, stay in ACCESS indefinitely, unless the timeout is enabled.
- DONE:
  - DONE is high for this single cycle. RDATA and ERR are valid.
  - The next edge clears DONE and returns to IDLE. RDATA and ERR hold until the next DONE.
  - REQ is ignored in the DONE state, so the requester has that cycle to deassert REQ.
- Latency and throughput:
  - Minimum transfer is REQ seen in IDLE → DONE high 3 cycles later.
  - One transfer takes at least 4 cycles, so two back-to-back transfers need at least 8 cycles.
  - Each PREADY=0 cycle in ACCESS adds one cycle.
- Requester changes to REQ_* after grant have no effect on the bus.
- A requester dropping REQ after grant but before DONE does not abort the transfer; DONE still pulses.
- Address and data widths pass through directly, with no truncation.

Optional Feature:
- Macro: APB_RR_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT with PREADY still 0: abort with ERR=1 and RDATA=0, drop the bus signals to 0, pulse DONE[GNT_ID], advance the pointer and go to DONE.
  - If PREADY=1 on the same edge the counter would reach TIMEOUT, the transfer completes normally with ERR=0.
- Not defined: no counter; ERR is constant 0; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset, then requester 0 writes addr 5'h03, data 32'hA5A5_0001 with PREADY tied 1 → SETUP cycle shows PSEL=1, PENABLE=0, PWRITE=1, PADDR=03, PWDATA=A5A50001. The next cycle shows PENABLE=1. DONE=2'b01 comes 3 cycles after REQ, with ERR=0, and the bus returns to 0.
- Requester 1 reads addr 5'h1F while the slave holds PREADY=0 for 3 ACCESS cycles, then returns PRDATA=32'hDEAD_BEEF → PSEL/PENABLE stay high for 4 ACCESS cycles. DONE=2'b10 with RDATA=DEADBEEF, and GNT_ID=1 throughout.
- Both REQ bits raised in the same cycle after reset, held until DONE → requester 0 is served first, then requester 1, with PSEL low for 2 cycles between. A third round with both requesting gives requester 0 again (alternation).
- RST_B pulled low during ACCESS of a requester 0 write → on the next edge all APB outputs are 0, DONE is never pulsed, and GNT_ID=0. After release, a fresh request from requester 1 completes normally.
- APB_RR_TIMEOUT_EN defined, TIMEOUT=4, PREADY held 0 → DONE pulses after 4 ACCESS cycles with ERR=1 and RDATA=0. With the macro undefined, the same stimulus keeps PSEL=PENABLE=1 for at least 100 cycles with no DONE.
- A requester changes REQ_ADDR from 5'h02 to 5'h07 during SETUP → PADDR stays 5'h02 until the transfer ends.
